// File: rtl/tag_sort_pkg.sv
// tag_sort_pkg: shared update opcodes, layer FSM states and the masked-update helper
package tag_sort_pkg;
  localparam logic UPD_SET = 1'b0;
  localparam logic UPD_CLR = 1'b1;
  localparam int MAX_W = 64;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  function automatic logic [MAX_W-1:0] apply_upd(input logic [MAX_W-1:0] word, input logic op, input logic [MAX_W-1:0] mask);
    return (op == UPD_CLR) ? (word & ~mask) : (word | mask);
  endfunction
endpackage

// File: rtl/tree_layer_rd_port.sv
// tree_layer_rd_port: one registered read port with forwarding of in-flight and same-cycle updates
module tree_layer_rd_port
  import tag_sort_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              s2_valid,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [DATA_W-1:0] s2_new,
  input  logic              acc,
  input  logic              upd_op,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_mask,
  output logic [DATA_W-1:0] data,
  output logic              zero
);
  logic [DATA_W-1:0] w_s2, w_new;
  assign w_s2  = (s2_valid && s2_addr == addr) ? s2_new : mem_word;
  assign w_new = (acc && upd_addr == addr) ? DATA_W'(apply_upd(MAX_W'(w_s2), upd_op, MAX_W'(upd_mask))) : w_s2;
  // capture the newest view of the word; the sweep hides contents as all-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      zero <= 1'b1;
    end else if (ena) begin
      data <= busy ? '0 : w_new;
      zero <= busy || (w_new == '0);
    end
  end
endmodule

// File: rtl/tree_layer_bitmap_mem.sv
// tree_layer_bitmap_mem: per-layer node bitmap store with init sweep, RMW updates and forwarding reads
module tree_layer_bitmap_mem
  import tag_sort_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NUM_RD = 2,
  parameter logic [DATA_W-1:0] INIT_WORD0 = 16'h0001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_zero,
  input  logic                     upd_valid,
  input  logic                     upd_op,
  input  logic [ADDR_W-1:0]        upd_addr,
  input  logic [DATA_W-1:0]        upd_mask,
  output logic                     upd_ready,
  output logic                     init_busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic acc, s2_valid, s2_op;
  logic [ADDR_W-1:0] s2_addr;
  logic [DATA_W-1:0] s2_mask, s2_base, s2_new, s1_base;
  assign upd_ready = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);
  assign acc       = upd_valid && upd_ready;
  assign s2_new    = DATA_W'(apply_upd(MAX_W'(s2_base), s2_op, MAX_W'(s2_mask)));
  assign s1_base   = (s2_valid && s2_addr == upd_addr) ? s2_new : mem[upd_addr];
  // FSM state and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // sweep one word per cycle and enter RUN after the last address
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == ST_INIT) begin
      cnt_nx   = cnt + 1'b1;
      state_nx = (&cnt) ? ST_RUN : ST_INIT;
    end
  end
  // S1 -> S2: latch the accepted request with its (forwarded) base word
  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else s2_valid <= acc;
    if (acc) begin
      s2_op   <= upd_op;
      s2_addr <= upd_addr;
      s2_mask <= upd_mask;
      s2_base <= s1_base;
    end
  end
  // array writes: sweep contents during INIT, S2 results during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_busy) mem[cnt] <= (cnt == '0) ? INIT_WORD0 : '0;
      else if (s2_valid) mem[s2_addr] <= s2_new;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    tree_layer_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port (
      .clk(clk), .rst(rst), .ena(ena), .busy(init_busy),
      .addr(rd_addr[k*ADDR_W +: ADDR_W]),
      .mem_word(mem[rd_addr[k*ADDR_W +: ADDR_W]]),
      .s2_valid(s2_valid), .s2_addr(s2_addr), .s2_new(s2_new),
      .acc(acc), .upd_op(upd_op), .upd_addr(upd_addr), .upd_mask(upd_mask),
      .data(rd_data[k*DATA_W +: DATA_W]), .zero(rd_zero[k])
    );
  end
endmodule
